// File: rtl/bypass_network_pkg.sv
// Shared definitions for the bypass network.
//   slot_flags_t  : control part of an in-flight slot record. The full record is
//                   {valid, write_enable, address, data_valid, data}. Address and data
//                   widths depend on module parameters, so they live in parallel arrays
//                   next to the flags.
//   ZERO_REGISTER : hard-wired zero register; its value is never forwarded.
package bypass_network_pkg;

  localparam int ZERO_REGISTER = 0;

  typedef struct packed {
    logic valid;         // slot holds a real instruction (not a bubble)
    logic write_enable;  // instruction writes a destination register
    logic data_valid;    // result already captured into the slot
  } slot_flags_t;

endpackage

// File: rtl/bypass_port_select.sv
// Operand resolve for one decode read port.
// Scans the in-flight slots from youngest (slot 0) to oldest and picks the first
// producer of read_address. Its stored data, or its same-cycle result, is forwarded.
// A producer without data raises hazard and is never skipped in favour of an older slot.
// Ports:
//   slot_flags / slot_address / slot_data : in-flight slot records
//   result_valid / result_data            : per-slot results produced this cycle
//   read_address / regfile_data           : operand address and register-file value
//   read_data                             : resolved operand
//   hazard                                : youngest producer has no data yet
module bypass_port_select
  import bypass_network_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int STAGES     = 3
) (
  input  logic [STAGES-1:0]                 result_valid,
  input  logic [STAGES*DATA_WIDTH-1:0]      result_data,
  input  slot_flags_t [STAGES-1:0]          slot_flags,
  input  logic [STAGES-1:0][ADDR_WIDTH-1:0] slot_address,
  input  logic [STAGES-1:0][DATA_WIDTH-1:0] slot_data,
  input  logic [ADDR_WIDTH-1:0]             read_address,
  input  logic [DATA_WIDTH-1:0]             regfile_data,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              hazard
);

  logic                  hit;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_data;

  // Walk oldest to youngest so the youngest matching slot overwrites the selection.
  always_comb begin
    hit       = 1'b0;
    sel_ready = 1'b0;
    sel_data  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (slot_flags[k].valid && slot_flags[k].write_enable &&
          slot_address[k] == read_address) begin
        hit = 1'b1;
        if (slot_flags[k].data_valid) begin
          sel_ready = 1'b1;
          sel_data  = slot_data[k];
        end else if (result_valid[k]) begin
          sel_ready = 1'b1;
          sel_data  = result_data[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          sel_ready = 1'b0;
          sel_data  = '0;
        end
      end
    end
    // The zero register always comes from the register file.
    if (read_address == ADDR_WIDTH'(ZERO_REGISTER)) begin
      hit = 1'b0;
    end
  end

  assign hazard    = hit && !sel_ready;
  assign read_data = (hit && sel_ready) ? sel_data : regfile_data;

endmodule

// File: rtl/bypass_network.sv
// Operand-forwarding and load-use interlock unit.
// Tracks STAGES in-flight writebacks (slot 0 = EX, slot STAGES-1 = WB) in a shift
// pipeline and resolves READ_PORTS decode operands to the newest available value.
// stall is purely combinational and asks decode to hold while slot 0 takes a bubble.
// Ports:
//   clock, reset (async, active-high)
//   issue_write_enable / issue_write_address : decode-stage destination
//   flush                                    : discard the instruction entering slot 0
//   result_valid / result_data               : per-slot results produced this cycle
//   read_address / regfile_data              : decode operand addresses and RF data
//   read_data / stall                        : resolved operands and interlock request
// Optional build macro BYPASS_STALL_COUNT_EN adds stall_count (saturating count of
// stalled cycles, reset to 0).
module bypass_network
  import bypass_network_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int STAGES     = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             issue_write_enable,
  input  logic [ADDR_WIDTH-1:0]            issue_write_address,
  input  logic                             flush,
  input  logic [STAGES-1:0]                result_valid,
  input  logic [STAGES*DATA_WIDTH-1:0]     result_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
  input  logic [READ_PORTS*DATA_WIDTH-1:0] regfile_data,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic                             stall
`ifdef BYPASS_STALL_COUNT_EN
  ,
  output logic [31:0]                      stall_count
`endif
);

  slot_flags_t [STAGES-1:0]          flags_q, flags_d;
  logic [STAGES-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]                 capture;
  logic [READ_PORTS-1:0]             hazard;
  logic                              issue_accept;

  // ---- decode -> slot 0 / slot k-1 -> slot k ----
  assign issue_accept = !stall && !flush;

  // A result is captured only once; later results for the same entry are ignored.
  always_comb begin
    capture = '0;
    for (int k = 0; k < STAGES; k++) begin
      capture[k] = result_valid[k] && flags_q[k].valid &&
                   flags_q[k].write_enable && !flags_q[k].data_valid;
    end
  end

  always_comb begin
    flags_d = flags_q;
    addr_d  = addr_q;
    data_d  = data_q;

    flags_d[0].valid        = issue_accept;
    flags_d[0].write_enable = issue_write_enable;
    flags_d[0].data_valid   = 1'b0;
    addr_d[0]               = issue_write_address;
    data_d[0]               = '0;

    // Slots 1..STAGES-1 always advance; stall only inserts the bubble at slot 0.
    for (int k = 1; k < STAGES; k++) begin
      flags_d[k]            = flags_q[k-1];
      flags_d[k].data_valid = flags_q[k-1].data_valid || capture[k-1];
      addr_d[k]             = addr_q[k-1];
      data_d[k]             = capture[k-1] ?
                              result_data[(k-1)*DATA_WIDTH +: DATA_WIDTH] : data_q[k-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Address and data are qualified by the flags, so they need no reset.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // ---- operand resolve (combinational) ----
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    bypass_port_select #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .STAGES     (STAGES)
    ) u_select (
      .result_valid (result_valid),
      .result_data  (result_data),
      .slot_flags   (flags_q),
      .slot_address (addr_q),
      .slot_data    (data_q),
      .read_address (read_address[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .regfile_data (regfile_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .read_data    (read_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .hazard       (hazard[p])
    );
  end

  assign stall = |hazard;

`ifdef BYPASS_STALL_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != 32'hFFFF_FFFF) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_bypass_network.sv
module tb_bypass_network;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int ST = 3;

  logic               clock = 1'b0;
  logic               reset;
  logic               issue_write_enable;
  logic [AW-1:0]      issue_write_address;
  logic               flush;
  logic [ST-1:0]      result_valid;
  logic [ST*DW-1:0]   result_data;
  logic [RP*AW-1:0]   read_address;
  logic [RP*DW-1:0]   regfile_data;
  logic [RP*DW-1:0]   read_data;
  logic               stall;
`ifdef BYPASS_STALL_COUNT_EN
  logic [31:0]        stall_count;
`endif

  bypass_network #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .READ_PORTS (RP),
    .STAGES     (ST)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .issue_write_enable  (issue_write_enable),
    .issue_write_address (issue_write_address),
    .flush               (flush),
    .result_valid        (result_valid),
    .result_data         (result_data),
    .read_address        (read_address),
    .regfile_data        (regfile_data),
    .read_data           (read_data),
    .stall               (stall)
`ifdef BYPASS_STALL_COUNT_EN
    ,
    .stall_count         (stall_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [64:0] val;   // {stall, port1, port0}
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic set_issue(input logic we, input logic [AW-1:0] wa, input logic fl);
    issue_write_enable  = we;
    issue_write_address = wa;
    flush               = fl;
  endtask

  task automatic set_result(input logic [ST-1:0] rv, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    result_valid = rv;
    result_data  = {d2, d1, d0};
  endtask

  task automatic set_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] f0, input logic [DW-1:0] f1);
    read_address = {a1, a0};
    regfile_data = {f1, f0};
  endtask

  task automatic expect_out(input string name, input logic s,
                            input logic [DW-1:0] r0, input logic [DW-1:0] r1);
    exp_t x;
    x.name = name;
    x.val  = {s, r1, r0};
    sb.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_issue(1'b0, '0, 1'b0);
    set_result('0, '0, '0, '0);
    set_read('0, '0, '0, '0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_issue(1'b1, 5'd5, 1'b0);
    set_result('0, '0, '0, '0);
    set_read(5'd5, 5'd6, 32'h11, 32'h22);
    expect_out("reset_outputs", 1'b0, 32'h11, 32'h22);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_forward_chain();
    logic [DW-1:0] chain [4];
    chain[0] = 32'h0000_1100; chain[1] = 32'h0000_1120;
    chain[2] = 32'h0000_5520; chain[3] = 32'h0000_5564;
    do_reset();
    set_issue(1'b1, 5'd5, 1'b0);
    set_read(5'd0, 5'd0, '0, '0);
    expect_out("chain_first_issue", 1'b0, '0, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    // Each ori reads $5 produced by the previous one in slot 0 this cycle.
    for (int i = 0; i < 4; i++) begin
      set_issue(i < 3, 5'd5, 1'b0);
      set_result(3'b001, chain[i], '0, '0);
      if (i == 3) begin
        set_read(5'd5, 5'd5, 32'hBAD, 32'hBEEF);
        expect_out("chain_both_ports", 1'b0, chain[i], chain[i]);
      end else begin
        set_read(5'd5, 5'd0, 32'hBAD, '0);
        expect_out($sformatf("chain_step%0d", i), 1'b0, chain[i], '0);
      end
      #2; e = sb.pop_front(); checks++;
      if ({stall, read_data} !== e.val) begin
        errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
      end
      next_cycle();
    end
    set_issue(1'b0, '0, 1'b0);
    set_result('0, '0, '0, '0);
    set_read(5'd5, 5'd0, 32'hBAD, '0);
    expect_out("chain_captured_slot1", 1'b0, 32'h5564, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    set_issue(1'b1, 5'd5, 1'b0);                     // lw $5
    set_read(5'd0, 5'd0, '0, '0);
    next_cycle();
    set_issue(1'b1, 5'd6, 1'b0);                     // addu $6 using $5
    set_read(5'd5, 5'd0, 32'h0BAD, '0);
    expect_out("load_use_stall", 1'b1, 32'h0BAD, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    set_result(3'b010, '0, 32'hDEAD_BEEF, '0);
    expect_out("load_use_bypass_slot1", 1'b0, 32'hDEAD_BEEF, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    // Bubble is now in slot 1; the load sits in slot 2 with captured data.
    set_issue(1'b1, 5'd7, 1'b0);
    set_result(3'b001, 32'h0000_600D, '0, '0);
    set_read(5'd5, 5'd6, 32'h0BAD, 32'h0C0C);
    expect_out("load_persist_and_addu", 1'b0, 32'hDEAD_BEEF, 32'h0000_600D);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    // Two-slot latency load: result only from slot 2.
    set_issue(1'b1, 5'd8, 1'b0);
    set_result('0, '0, '0, '0);
    set_read(5'd0, 5'd0, '0, '0);
    next_cycle();
    set_issue(1'b1, 5'd9, 1'b0);
    set_read(5'd8, 5'd0, 32'h0BAD, '0);
    for (int i = 0; i < 2; i++) begin
      expect_out($sformatf("two_slot_stall%0d", i), 1'b1, 32'h0BAD, '0);
      #2; e = sb.pop_front(); checks++;
      if ({stall, read_data} !== e.val) begin
        errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
      end
      next_cycle();
    end
    set_result(3'b100, '0, '0, 32'h8888_0008);
    expect_out("two_slot_bypass", 1'b0, 32'h8888_0008, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
`ifdef BYPASS_STALL_COUNT_EN
    checks++;
    if (stall_count !== 32'd3) begin
      errors++; $display("FAIL stall_count: got %0d required 3", stall_count);
    end
`endif
    next_cycle();
  endtask

  task automatic test_youngest_wins();
    do_reset();
    set_issue(1'b1, 5'd5, 1'b0);
    set_read(5'd0, 5'd0, '0, '0);
    next_cycle();
    set_issue(1'b1, 5'd6, 1'b0);
    set_result(3'b001, 32'h0000_1234, '0, '0);
    next_cycle();
    set_issue(1'b1, 5'd5, 1'b0);
    set_result('0, '0, '0, '0);
    next_cycle();
    // Slot 0: $5 without data, slot 2: $5 = 0x1234.
    set_issue(1'b0, '0, 1'b0);
    set_read(5'd5, 5'd5, 32'h77, 32'h77);
    expect_out("young_no_data_stalls", 1'b1, 32'h77, 32'h77);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    set_result(3'b001, 32'hAAAA_0000, '0, '0);
    expect_out("young_same_cycle", 1'b0, 32'hAAAA_0000, 32'hAAAA_0000);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
  endtask

  task automatic test_zero_and_flush();
    do_reset();
    set_issue(1'b1, 5'd0, 1'b0);
    set_read(5'd0, 5'd0, '0, '0);
    repeat (3) next_cycle();
    expect_out("zero_no_stall", 1'b0, '0, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    set_result(3'b111, 32'hAAAA, 32'hBBBB, 32'hCCCC);
    expect_out("zero_never_forwarded", 1'b0, '0, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    do_reset();
    set_issue(1'b1, 5'd5, 1'b0);
    next_cycle();
    set_issue(1'b1, 5'd7, 1'b1);                     // flush while stalled
    set_read(5'd5, 5'd0, 32'h0BAD, '0);
    expect_out("flush_during_stall", 1'b1, 32'h0BAD, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    set_issue(1'b1, 5'd8, 1'b1);                     // flush without stall
    set_read(5'd7, 5'd0, 32'h99, '0);
    expect_out("flush_stall_bubble", 1'b0, 32'h99, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
    set_issue(1'b0, '0, 1'b0);
    set_read(5'd8, 5'd0, 32'h42, '0);
    expect_out("flush_bubble", 1'b0, 32'h42, '0);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    for (int i = 5; i <= 7; i++) begin
      set_issue(1'b1, AW'(i), 1'b0);
      next_cycle();
    end
    set_issue(1'b0, '0, 1'b0);
    set_read(5'd5, 5'd6, 32'h31, 32'h32);
    expect_out("pre_reset_stall", 1'b1, 32'h31, 32'h32);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    reset = 1'b1;
    expect_out("async_reset_clears_stall", 1'b0, 32'h31, 32'h32);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
`ifdef BYPASS_STALL_COUNT_EN
    checks++;
    if (stall_count !== 32'd0) begin
      errors++; $display("FAIL stall_count_reset: got %0d required 0", stall_count);
    end
`endif
    next_cycle();
    reset = 1'b0;
    expect_out("post_reset_empty", 1'b0, 32'h31, 32'h32);
    #2; e = sb.pop_front(); checks++;
    if ({stall, read_data} !== e.val) begin
      errors++; $display("FAIL %s: got %h required %h", e.name, {stall, read_data}, e.val);
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_issue(1'b0, '0, 1'b0);
    set_result('0, '0, '0, '0);
    set_read('0, '0, '0, '0);
    #1;
    test_reset();
    test_forward_chain();
    test_load_use();
    test_youngest_wins();
    test_zero_and_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
